// File: rtl/multi_stay_latch_if.sv
// Event-latch status bus: raw event lines and controls in, latched status and
// episode/statistics reporting out.
interface multi_stay_latch_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] x;
  logic [CHANNELS-1:0] clear;
  logic                mode;
  logic [CHANNELS-1:0] y;
  logic                any;
  logic [IDX_W-1:0]    first_idx;
  logic                first_valid;
  logic [CNT_W-1:0]    event_count;

  modport master (
    output x, clear, mode,
    input  y, any, first_idx, first_valid, event_count
  );

  modport slave (
    input  x, clear, mode,
    output y, any, first_idx, first_valid, event_count
  );
endinterface

// File: rtl/multi_stay_latch.sv
// Multi-channel qualified sticky/release event latch with first-latched index and saturating event count.
// Latency: QUAL_CYCLES edges from x high to y high; one edge for clear/release; no backpressure (status only).
module multi_stay_latch #(
  parameter int CHANNELS    = 8,
  parameter int QUAL_CYCLES = 4,
  parameter int CNT_W       = 16,
  parameter int IDX_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  multi_stay_latch_if.slave bus
);

  // The counter only ever holds 1..QUAL_CYCLES-1 while qualifying.
  localparam int QCW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
  localparam logic [QCW-1:0] QUAL_LAST = QCW'(QUAL_CYCLES - 1);
  localparam int POP_W = $clog2(CHANNELS + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_LATCHED = 2'd2
  } state_t;

  state_t              state [CHANNELS];
  logic [QCW-1:0]      cnt   [CHANNELS];
  logic [CHANNELS-1:0] y_q;
  logic [IDX_W-1:0]    first_idx_q;
  logic                first_valid_q;
  logic [CNT_W-1:0]    count_q;

  logic [CHANNELS-1:0] enter;
  logic [CHANNELS-1:0] stay;
  logic [POP_W-1:0]    pop;
  logic [IDX_W-1:0]    lowest;
  logic [SUM_W-1:0]    sum;

  // enter: channel reaches LATCHED on this edge; stay: already LATCHED and remains so.
  always_comb begin
    enter  = '0;
    stay   = '0;
    pop    = '0;
    lowest = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state[i])
        S_IDLE:    enter[i] = bus.x[i] && (QUAL_CYCLES == 1);
        S_QUALIFY: enter[i] = bus.x[i] && (cnt[i] == QUAL_LAST);
        S_LATCHED: stay[i]  = bus.x[i] || !bus.mode;
        default:   ;
      endcase
      if (bus.clear[i]) begin
        enter[i] = 1'b0;
        stay[i]  = 1'b0;
      end
      pop = pop + POP_W'(enter[i]);
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (enter[i]) lowest = IDX_W'(i);
    end
    sum = SUM_W'(count_q) + SUM_W'(pop);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
      y_q           <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.clear[i]) begin
          state[i] <= S_IDLE;
          cnt[i]   <= '0;
        end else begin
          case (state[i])
            S_IDLE: begin
              if (bus.x[i]) begin
                if (QUAL_CYCLES == 1) begin
                  state[i] <= S_LATCHED;
                end else begin
                  state[i] <= S_QUALIFY;
                  cnt[i]   <= QCW'(1);
                end
              end
            end
            S_QUALIFY: begin
              if (!bus.x[i]) begin
                state[i] <= S_IDLE;
                cnt[i]   <= '0;
              end else if (cnt[i] == QUAL_LAST) begin
                state[i] <= S_LATCHED;
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= cnt[i] + QCW'(1);
              end
            end
            S_LATCHED: begin
              if (bus.mode && !bus.x[i]) state[i] <= S_IDLE;
            end
            default: begin
              state[i] <= S_IDLE;
              cnt[i]   <= '0;
            end
          endcase
        end
      end

      y_q     <= enter | stay;
      count_q <= (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

      // An episode lasts while any channel is latched after the edge; a
      // same-edge handover (all leave, another enters) keeps the old index.
      if (!first_valid_q) begin
        if (|enter) begin
          first_idx_q   <= lowest;
          first_valid_q <= 1'b1;
        end
      end else if (!(|(enter | stay))) begin
        first_valid_q <= 1'b0;
      end
    end
  end

  assign bus.y           = reset ? y_q : '0;
  assign bus.any         = reset ? (|y_q) : 1'b0;
  assign bus.first_idx   = reset ? first_idx_q : '0;
  assign bus.first_valid = reset ? first_valid_q : 1'b0;
  assign bus.event_count = reset ? count_q : '0;

endmodule

// File: tb/tb_multi_stay_latch.sv
// Directed bench for multi_stay_latch: main instance (QUAL_CYCLES=4, CNT_W=16)
// plus a single-cycle, 4-bit-count instance for latency and saturation.
module tb_multi_stay_latch;

  logic clock_100Mhz;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multi_stay_latch_if #(.CHANNELS(8), .CNT_W(16), .IDX_W(3)) bus  ();
  multi_stay_latch_if #(.CHANNELS(8), .CNT_W(4),  .IDX_W(3)) bus2 ();

  multi_stay_latch #(.CHANNELS(8), .QUAL_CYCLES(4), .CNT_W(16), .IDX_W(3)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .bus          (bus)
  );

  multi_stay_latch #(.CHANNELS(8), .QUAL_CYCLES(1), .CNT_W(4), .IDX_W(3)) dut2 (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .bus          (bus2)
  );

  initial clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_100Mhz);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] y, input logic [2:0] idx,
                           input logic vld, input logic [15:0] cnt);
    check({tag, ".y"},     bus.y, y);
    check({tag, ".any"},   bus.any, |y);
    check({tag, ".idx"},   bus.first_idx, idx);
    check({tag, ".vld"},   bus.first_valid, vld);
    check({tag, ".count"}, bus.event_count, cnt);
  endtask

  initial begin
    reset      = 1'b0;
    bus.x      = 8'hFF;
    bus.clear  = 8'h00;
    bus.mode   = 1'b0;
    bus2.x     = 8'hFF;
    bus2.clear = 8'h00;
    bus2.mode  = 1'b0;

    // Reset with all inputs high: outputs are gated to zero throughout.
    #1;
    check_all("rst_t0", 8'h00, 3'd0, 1'b0, 16'd0);
    check("rst_t0.y2", bus2.y, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_all("rst_hold", 8'h00, 3'd0, 1'b0, 16'd0);
    end
    bus.x  = 8'h00;
    bus2.x = 8'h00;
    reset  = 1'b1;
    step(2);
    check_all("rst_idle", 8'h00, 3'd0, 1'b0, 16'd0);

    // Qualification: 3 highs, a gap, then 4 highs latch channel 2.
    bus.x = 8'h04;
    step(3);
    check("qual_3hi.y", bus.y, 8'h00);
    bus.x = 8'h00;
    step(1);
    check("qual_gap.y", bus.y, 8'h00);
    bus.x = 8'h04;
    step(3);
    check_all("qual_re3", 8'h00, 3'd0, 1'b0, 16'd0);
    step(1);
    check_all("qual_lat", 8'h04, 3'd2, 1'b1, 16'd1);

    // Sticky holds with x low; switching to release drops it one edge later.
    bus.x = 8'h00;
    step(2);
    check_all("sticky", 8'h04, 3'd2, 1'b1, 16'd1);
    bus.mode = 1'b1;
    step(1);
    check_all("release", 8'h00, 3'd2, 1'b0, 16'd1);
    bus.mode = 1'b0;

    // Channels 5 and 1 complete on the same edge; lowest index wins.
    bus.x = 8'h22;
    step(3);
    check("simul_3.y", bus.y, 8'h00);
    step(1);
    check_all("simul", 8'h22, 3'd1, 1'b1, 16'd3);

    // Clear ch5, requalify, and clear again on the completing edge.
    bus.clear = 8'h20;
    step(1);
    check_all("clr5", 8'h02, 3'd1, 1'b1, 16'd3);
    bus.clear = 8'h00;
    step(3);
    check("requal_3.y", bus.y, 8'h02);
    bus.clear = 8'h20;
    step(1);
    check_all("clr_prio", 8'h02, 3'd1, 1'b1, 16'd3);
    bus.clear = 8'h00;
    step(3);
    check("requal2_3.y", bus.y, 8'h02);
    step(1);
    check_all("requal2", 8'h22, 3'd1, 1'b1, 16'd4);

    // Reset while ch1/ch5 latched and ch0 partway through qualifying.
    bus.x = 8'h23;
    step(2);
    check("pre_rst.y", bus.y, 8'h22);
    reset = 1'b0;
    #1;
    check_all("rst_comb", 8'h00, 3'd0, 1'b0, 16'd0);
    step(1);
    check_all("rst_edge", 8'h00, 3'd0, 1'b0, 16'd0);
    reset = 1'b1;
    step(3);
    check_all("relat_3", 8'h00, 3'd0, 1'b0, 16'd0);
    step(1);
    check_all("relat", 8'h23, 3'd0, 1'b1, 16'd3);

    // Single-cycle latency and 4-bit saturation on the second instance.
    bus2.mode = 1'b1;
    bus2.x    = 8'h0F;
    step(1);
    check("sat_a.y",     bus2.y, 8'h0F);
    check("sat_a.count", bus2.event_count, 4'd4);
    check("sat_a.idx",   bus2.first_idx, 3'd0);
    check("sat_a.vld",   bus2.first_valid, 1'b1);
    bus2.x = 8'h00;
    step(1);
    check("sat_b.y",     bus2.y, 8'h00);
    check("sat_b.vld",   bus2.first_valid, 1'b0);
    bus2.x = 8'hF0;
    step(1);
    check("sat_c.count", bus2.event_count, 4'd8);
    check("sat_c.idx",   bus2.first_idx, 3'd4);
    bus2.x = 8'h00;
    step(1);
    bus2.x = 8'hFF;
    step(1);
    check("sat_d.count", bus2.event_count, 4'd15);
    check("sat_d.y",     bus2.y, 8'hFF);
    bus2.x = 8'h00;
    step(1);
    bus2.x = 8'hFF;
    step(1);
    check("sat_e.count", bus2.event_count, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
